// File: rtl/ysyx_220066_memarb.sv
// ysyx_220066_memarb
// Arbitrates one instruction-fetch port and one load/store port onto a
// single 64-bit doubleword bus. Data requests win over fetches. Each granted
// request is latched, presented on the bus until bus_ready, and answered with
// a one-cycle ready pulse. Misaligned accesses and bus timeouts park the
// block in an error state that only reset leaves.
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   if_req/if_addr                 fetch request, held until if_ready
//   if_ready/if_rdata              fetch done pulse, 32-bit instruction
//   mem_req/mem_wr/mem_op          load/store request, store flag, size/sign code
//   mem_addr/mem_wdata             data address, LSB-aligned store data
//   mem_ready/mem_rdata            access done pulse, extended load result
//   bus_valid/bus_wr/bus_addr      bus request, write flag, doubleword address
//   bus_wmask/bus_wdata            byte-lane enables, lane-shifted store data
//   bus_ready/bus_rdata            bus completion, read doubleword
//   error                          sticky fault flag
module ysyx_220066_memarb #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   input  logic        mem_req,
   input  logic        mem_wr,
   input  logic [2:0]  mem_op,
   input  logic [63:0] mem_addr,
   input  logic [63:0] mem_wdata,
   output logic        mem_ready,
   output logic [63:0] mem_rdata,
   output logic        bus_valid,
   output logic        bus_wr,
   output logic [63:0] bus_addr,
   output logic [7:0]  bus_wmask,
   output logic [63:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [63:0] bus_rdata,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      IF_BUSY  = 3'd1,
      MEM_BUSY = 3'd2,
      RESP     = 3'd3,
      ERR      = 3'd4
   } state_t;

   localparam logic [31:0] TIMEOUT_U = TIMEOUT;

   state_t      state;
   state_t      state_next;

   logic        serve_mem;
   logic        wr_q;
   logic [63:0] addr_q;
   logic [7:0]  wmask_q;
   logic [63:0] wdata_q;
   logic [2:0]  op_q;
   logic [2:0]  off_q;
   logic [15:0] cnt;
   logic [31:0] if_rdata_q;
   logic [63:0] mem_rdata_q;

   logic        mem_misaligned;
   logic        if_misaligned;
   logic [16:0] cnt_inc;
   logic        timeout_hit;
   logic [7:0]  mask_base;
   logic [7:0]  store_mask;
   logic [63:0] store_data;
   logic [63:0] load_shifted;
   logic [63:0] load_value;

   // An access is misaligned when it does not sit on its natural size
   // boundary; op 111 has no defined size and is always rejected.
   always_comb begin
      mem_misaligned = 1'b0;
      case (mem_op)
         3'b001, 3'b101: mem_misaligned = mem_addr[0];
         3'b010, 3'b110: mem_misaligned = (mem_addr[1:0] != 2'b00);
         3'b011:         mem_misaligned = (mem_addr[2:0] != 3'b000);
         3'b111:         mem_misaligned = 1'b1;
         default:        mem_misaligned = 1'b0;
      endcase
   end

   assign if_misaligned = (if_addr[1:0] != 2'b00);

   // The counter holds the number of BUSY cycles already spent without
   // bus_ready; the one now ending would make it cnt+1.
   assign cnt_inc     = {1'b0, cnt} + 17'd1;
   assign timeout_hit = (32'(cnt_inc) >= TIMEOUT_U);

   // Store lane placement: size mask and data both move up by the byte offset.
   always_comb begin
      mask_base = 8'hFF;
      case (mem_op[1:0])
         2'b00:   mask_base = 8'h01;
         2'b01:   mask_base = 8'h03;
         2'b10:   mask_base = 8'h0F;
         default: mask_base = 8'hFF;
      endcase
      store_mask = mask_base << mem_addr[2:0];
      store_data = mem_wdata << {mem_addr[2:0], 3'b000};
   end

   // Load extraction: bring the addressed byte to bit 0, then extend by op.
   always_comb begin
      load_shifted = bus_rdata >> {off_q, 3'b000};
      load_value   = load_shifted;
      case (op_q)
         3'b000:  load_value = {{56{load_shifted[7]}},  load_shifted[7:0]};
         3'b001:  load_value = {{48{load_shifted[15]}}, load_shifted[15:0]};
         3'b010:  load_value = {{32{load_shifted[31]}}, load_shifted[31:0]};
         3'b100:  load_value = {56'd0, load_shifted[7:0]};
         3'b101:  load_value = {48'd0, load_shifted[15:0]};
         3'b110:  load_value = {32'd0, load_shifted[31:0]};
         default: load_value = load_shifted;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and the state-decoded outputs.
   always_comb begin
      state_next = state;
      bus_valid  = 1'b0;
      if_ready   = 1'b0;
      mem_ready  = 1'b0;
      error      = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req) begin
               state_next = mem_misaligned ? ERR : MEM_BUSY;
            end else if (if_req) begin
               state_next = if_misaligned ? ERR : IF_BUSY;
            end
         end
         IF_BUSY, MEM_BUSY: begin
            bus_valid = 1'b1;
            if (bus_ready) begin
               state_next = RESP;
            end else if (timeout_hit) begin
               state_next = ERR;
            end
         end
         RESP: begin
            if_ready   = ~serve_mem;
            mem_ready  = serve_mem;
            state_next = IDLE;
         end
         ERR: begin
            error = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request latching, timeout counting and read-data capture. The read
   // result registers only change on completion so each requester keeps its
   // last value; a store completion leaves mem_rdata untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         serve_mem   <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wmask_q     <= '0;
         wdata_q     <= '0;
         op_q        <= '0;
         off_q       <= '0;
         cnt         <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (mem_req) begin
                  if (!mem_misaligned) begin
                     serve_mem <= 1'b1;
                     wr_q      <= mem_wr;
                     addr_q    <= {mem_addr[63:3], 3'b000};
                     off_q     <= mem_addr[2:0];
                     op_q      <= mem_op;
                     wmask_q   <= mem_wr ? store_mask : 8'h00;
                     wdata_q   <= mem_wr ? store_data : 64'd0;
                  end
               end else if (if_req && !if_misaligned) begin
                  serve_mem <= 1'b0;
                  wr_q      <= 1'b0;
                  addr_q    <= {if_addr[63:3], 3'b000};
                  off_q     <= if_addr[2:0];
                  op_q      <= 3'b000;
                  wmask_q   <= 8'h00;
                  wdata_q   <= 64'd0;
               end
            end
            IF_BUSY, MEM_BUSY: begin
               if (bus_ready) begin
                  if (state == MEM_BUSY) begin
                     if (!wr_q) begin
                        mem_rdata_q <= load_value;
                     end
                  end else begin
                     if_rdata_q <= off_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];
                  end
               end else begin
                  cnt <= cnt_inc[15:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus_wr    = wr_q;
   assign bus_addr  = addr_q;
   assign bus_wmask = wmask_q;
   assign bus_wdata = wdata_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_ysyx_220066_memarb.sv
// Testbench for ysyx_220066_memarb. Stimulus pushes expected bus transactions
// and expected ready responses into queues; an independent monitor pops and
// compares them whenever the DUT completes a bus transfer or pulses ready.
// A bus responder returns a fixed pseudo-random doubleword per address.
module tb_ysyx_220066_memarb;

   localparam int TO          = 4;
   localparam int MODE_RANDOM = 0;
   localparam int MODE_NOW    = 1;
   localparam int MODE_NEVER  = 2;
   localparam int MODE_ALWAYS = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [2:0]  mem_op;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_ready;
   logic [63:0] mem_rdata;
   logic        bus_valid;
   logic        bus_wr;
   logic [63:0] bus_addr;
   logic [7:0]  bus_wmask;
   logic [63:0] bus_wdata;
   logic        bus_ready;
   logic [63:0] bus_rdata;
   logic        error;

   ysyx_220066_memarb #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready),
      .if_rdata  (if_rdata),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_op    (mem_op),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .bus_valid (bus_valid),
      .bus_wr    (bus_wr),
      .bus_addr  (bus_addr),
      .bus_wmask (bus_wmask),
      .bus_wdata (bus_wdata),
      .bus_ready (bus_ready),
      .bus_rdata (bus_rdata),
      .error     (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_mem;
      logic [63:0] data;
   } resp_t;

   typedef struct packed {
      logic        wr;
      logic [63:0] addr;
      logic [7:0]  mask;
      logic [63:0] wdata;
   } bus_t;

   resp_t       resp_q[$];
   bus_t        bus_q[$];
   int          checks = 0;
   int          failures = 0;
   int          bus_mode = MODE_NOW;
   logic        use_override = 1'b0;
   logic [63:0] override_word = '0;
   logic [63:0] last_if_model = '0;
   logic [63:0] last_mem_model = '0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
      end
   endtask

   // Memory contents seen by the bus: a fixed scramble of the doubleword index.
   function automatic logic [63:0] rdword(input logic [63:0] a);
      logic [31:0] k;
      k = a[34:3];
      if (use_override) return override_word;
      return {k * 32'h9E37_79B1, k ^ 32'hC3A5_5A3C};
   endfunction

   // Reference load: gather the bytes of the access, then extend.
   function automatic logic [63:0] loadModel(input logic [63:0] word, input logic [2:0] op, input logic [2:0] off);
      int          size;
      logic [63:0] v;
      size = 1 << op[1:0];
      v    = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
      if (!op[2] && size < 8 && v[8*size-1]) begin
         for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
      end
      return v;
   endfunction

   task automatic pushBus(input logic wr, input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] wdata);
      bus_t b;
      b.wr = wr; b.addr = addr; b.mask = mask; b.wdata = wdata;
      bus_q.push_back(b);
   endtask

   task automatic pushResp(input logic is_mem, input logic [63:0] data);
      resp_t r;
      r.is_mem = is_mem; r.data = data;
      resp_q.push_back(r);
   endtask

   task automatic expectMem(input logic wr, input logic [2:0] op, input logic [63:0] a, input logic [63:0] wd);
      int          size;
      logic [15:0] m;
      logic [63:0] base;
      size = 1 << op[1:0];
      base = {a[63:3], 3'b000};
      if (wr) begin
         m = ((16'd1 << size) - 16'd1) << a[2:0];
         pushBus(1'b1, base, m[7:0], wd << (8 * a[2:0]));
      end else begin
         pushBus(1'b0, base, 8'h00, 64'd0);
         last_mem_model = loadModel(rdword(base), op, a[2:0]);
      end
      pushResp(1'b1, last_mem_model);
   endtask

   task automatic expectIf(input logic [63:0] a);
      logic [63:0] base;
      logic [63:0] w;
      base = {a[63:3], 3'b000};
      w    = rdword(base);
      pushBus(1'b0, base, 8'h00, 64'd0);
      last_if_model = {32'd0, a[2] ? w[63:32] : w[31:0]};
      pushResp(1'b0, last_if_model);
   endtask

   // Drive requests and hold each until its ready pulse, bounded in cycles.
   task automatic driveTxn(input bit do_if, input logic [63:0] ia, input bit do_mem, input logic mw,
                           input logic [2:0] mop, input logic [63:0] ma, input logic [63:0] wd);
      bit if_done, mem_done, if_seen, mem_seen;
      int budget;
      @(posedge clk); #1;
      if_req = do_if; if_addr = ia;
      mem_req = do_mem; mem_wr = mw; mem_op = mop; mem_addr = ma; mem_wdata = wd;
      if_done = !do_if; mem_done = !do_mem; budget = 0;
      while (!(if_done && mem_done) && budget < 60) begin
         @(negedge clk);
         if_seen = if_ready; mem_seen = mem_ready;
         @(posedge clk); #1;
         if (if_seen) begin if_done = 1'b1; if_req = 1'b0; if_addr = {$urandom, $urandom}; end
         if (mem_seen) begin mem_done = 1'b1; mem_req = 1'b0; mem_addr = {$urandom, $urandom}; end
         budget++;
      end
      if (!(if_done && mem_done)) checkOutput("txn_completion", {62'd0, if_done, mem_done}, 64'h3);
      if_req = 1'b0; mem_req = 1'b0;
   endtask

   task automatic applyStimulus(input bit do_if, input bit do_mem);
      logic [63:0] ia, ma, wd;
      logic        mw;
      logic [2:0]  mop;
      int          size;
      ia = {$urandom, $urandom}; ia[1:0] = 2'b00;
      mw = 1'($urandom_range(0, 1));
      mop = mw ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      size = 1 << mop[1:0];
      ma = {$urandom, $urandom}; ma[2:0] = ma[2:0] & 3'(~(size - 1));
      wd = {$urandom, $urandom};
      if (do_mem) expectMem(mw, mop, ma, wd);
      if (do_if) expectIf(ia);
      driveTxn(do_if, ia, do_mem, mw, mop, ma, wd);
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      rst = 1'b1; if_req = 1'b0; mem_req = 1'b0;
      resp_q.delete(); bus_q.delete();
      last_if_model = '0; last_mem_model = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic checkIdleOutputs(input string tag);
      @(negedge clk);
      checkOutput({tag, "_if_ready"},  if_ready,  0);
      checkOutput({tag, "_if_rdata"},  if_rdata,  0);
      checkOutput({tag, "_mem_ready"}, mem_ready, 0);
      checkOutput({tag, "_mem_rdata"}, mem_rdata, 0);
      checkOutput({tag, "_bus_valid"}, bus_valid, 0);
      checkOutput({tag, "_bus_wr"},    bus_wr,    0);
      checkOutput({tag, "_bus_addr"},  bus_addr,  0);
      checkOutput({tag, "_bus_wmask"}, bus_wmask, 0);
      checkOutput({tag, "_bus_wdata"}, bus_wdata, 0);
      checkOutput({tag, "_error"},     error,     0);
   endtask

   // Bus responder: answers after 0..2 wait cycles in random mode.
   initial begin : responder
      int waited;
      int limit;
      bus_ready = 1'b0; bus_rdata = '0; waited = 0; limit = 0;
      forever begin
         @(posedge clk); #1;
         if (bus_mode == MODE_ALWAYS) begin
            bus_ready = 1'b1;
         end else if (!bus_valid) begin
            bus_ready = 1'b0; waited = 0; limit = $urandom_range(0, 2);
         end else begin
            case (bus_mode)
               MODE_NOW:   bus_ready = 1'b1;
               MODE_NEVER: bus_ready = 1'b0;
               default:    bus_ready = (waited >= limit);
            endcase
            waited++;
         end
         bus_rdata = bus_ready ? rdword(bus_addr) : {$urandom, $urandom};
      end
   end

   // Monitor: compares every ready pulse and bus completion against the queues.
   always @(negedge clk) begin : monitor
      resp_t r;
      bus_t  b;
      if (!rst) begin
         if (if_ready || mem_ready) begin
            if (resp_q.size() == 0 || (if_ready && mem_ready)) begin
               checkOutput("spurious_ready", {62'd0, if_ready, mem_ready}, 64'd0);
            end else begin
               r = resp_q.pop_front();
               checkOutput("ready_source", {63'd0, mem_ready}, {63'd0, r.is_mem});
               if (r.is_mem) checkOutput("mem_rdata", mem_rdata, r.data);
               else checkOutput("if_rdata", {32'd0, if_rdata}, r.data);
            end
         end
         if (bus_valid && bus_ready) begin
            if (bus_q.size() == 0) begin
               checkOutput("spurious_bus_txn", {63'd0, bus_valid}, 64'd0);
            end else begin
               b = bus_q.pop_front();
               checkOutput("bus_wr", bus_wr, b.wr);
               checkOutput("bus_addr", bus_addr, b.addr);
               checkOutput("bus_wmask", bus_wmask, b.mask);
               if (b.wr) checkOutput("bus_wdata", bus_wdata, b.wdata);
            end
         end
         if (error) checkOutput("err_bus_valid", {63'd0, bus_valid}, 64'd0);
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int busy_cycles;
      int n;
      rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_wr = 1'b0;
      mem_op = '0; mem_addr = '0; mem_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkIdleOutputs("reset");

      // Fetch from the upper word with an immediate bus answer.
      bus_mode = MODE_NOW; use_override = 1'b1; override_word = 64'h0010_0093_DEAD_BEEF;
      pushBus(1'b0, 64'h8000_0000, 8'h00, 64'd0);
      pushResp(1'b0, 64'h0000_0000_0010_0093);
      last_if_model = 64'h0010_0093;
      @(posedge clk); #1 if_req = 1'b1; if_addr = 64'h8000_0004;
      @(negedge clk); checkOutput("fetch_idle_valid", bus_valid, 0);
      @(negedge clk); checkOutput("fetch_busy_valid", bus_valid, 1);
      checkOutput("fetch_busy_ready", if_ready, 0);
      @(negedge clk); checkOutput("fetch_resp_ready", if_ready, 1);
      @(posedge clk); #1 if_req = 1'b0;
      @(negedge clk); checkOutput("fetch_pulse_end", if_ready, 0);
      checkOutput("fetch_rdata_hold", if_rdata, 64'h0010_0093);

      // Halfword store at byte 6.
      use_override = 1'b0;
      pushBus(1'b1, 64'h1000, 8'hC0, 64'hABCD_0000_0000_0000);
      pushResp(1'b1, last_mem_model);
      driveTxn(1'b0, 64'd0, 1'b1, 1'b1, 3'b001, 64'h1006, 64'hABCD);

      // Byte loads from 0x00000000_80FF0000: byte 2 is 0xFF, byte 3 is 0x80.
      use_override = 1'b1; override_word = 64'h0000_0000_80FF_0000;
      pushBus(1'b0, 64'h2000, 8'h00, 64'd0);
      pushResp(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      driveTxn(1'b0, 64'd0, 1'b1, 1'b0, 3'b000, 64'h2002, 64'd0);
      pushBus(1'b0, 64'h2000, 8'h00, 64'd0);
      pushResp(1'b1, 64'h0000_0000_0000_00FF);
      driveTxn(1'b0, 64'd0, 1'b1, 1'b0, 3'b100, 64'h2002, 64'd0);
      pushBus(1'b0, 64'h2000, 8'h00, 64'd0);
      pushResp(1'b1, 64'hFFFF_FFFF_FFFF_FF80);
      driveTxn(1'b0, 64'd0, 1'b1, 1'b0, 3'b000, 64'h2003, 64'd0);
      last_mem_model = 64'hFFFF_FFFF_FFFF_FF80;
      use_override = 1'b0;

      // Simultaneous requests: data first, then fetch.
      bus_mode = MODE_RANDOM;
      applyStimulus(1'b1, 1'b1);

      for (int i = 0; i < 150; i++) begin
         n = $urandom_range(0, 2);
         applyStimulus(n != 1, n != 0);
      end
      checkOutput("resp_queue_drained", resp_q.size(), 0);
      checkOutput("bus_queue_drained", bus_q.size(), 0);

      // Reset in the middle of a bus transfer abandons it silently.
      bus_mode = MODE_NEVER;
      @(posedge clk); #1 if_req = 1'b1; if_addr = 64'h4000;
      @(negedge clk); @(negedge clk); checkOutput("abandon_busy_valid", bus_valid, 1);
      @(posedge clk); #1 rst = 1'b1; if_req = 1'b0; bus_mode = MODE_ALWAYS;
      @(posedge clk); #1 rst = 1'b0;
      last_if_model = '0; last_mem_model = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); checkOutput("abandon_no_valid", bus_valid, 0);
      end
      checkOutput("abandon_if_rdata", if_rdata, 0);
      checkOutput("abandon_mem_rdata", mem_rdata, 0);
      bus_mode = MODE_RANDOM;

      // Misaligned word load never reaches the bus.
      @(posedge clk); #1 mem_req = 1'b1; mem_wr = 1'b0; mem_op = 3'b010; mem_addr = 64'h3002;
      @(negedge clk); checkOutput("misalign_pre_error", error, 0);
      @(negedge clk); checkOutput("misalign_error", error, 1);
      checkOutput("misalign_bus_valid", bus_valid, 0);
      repeat (3) @(negedge clk);
      checkOutput("misalign_sticky", error, 1);
      doReset();
      checkIdleOutputs("misalign_rst");

      // Misaligned fetch.
      @(posedge clk); #1 if_req = 1'b1; if_addr = 64'h8000_0002;
      @(negedge clk); @(negedge clk);
      checkOutput("if_misalign_error", error, 1);
      doReset();
      checkIdleOutputs("if_misalign_rst");

      // Bus never answers: error after TO busy cycles.
      bus_mode = MODE_NEVER;
      @(posedge clk); #1 mem_req = 1'b1; mem_wr = 1'b0; mem_op = 3'b011; mem_addr = 64'h5000;
      busy_cycles = 0; n = 0;
      do begin
         @(negedge clk);
         if (bus_valid) busy_cycles++;
         n++;
      end while (!error && n < 20);
      checkOutput("timeout_error", error, 1);
      checkOutput("timeout_busy_cycles", busy_cycles, TO);
      mem_req = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("timeout_sticky", error, 1);
      doReset();
      checkIdleOutputs("timeout_rst");
      bus_mode = MODE_RANDOM;

      applyStimulus(1'b1, 1'b1);
      checkOutput("final_resp_queue", resp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
